// File: rtl/mem_stage_pkg.sv
// Purpose: shared types and constants for the memory-access stage.
//   memop_t : memory operation encoding (3 bits; codes 6 and 7 behave as NONE)
//   state_t : stage FSM states
//   BE_*    : byte-lane enable masks
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned RD_W   = 5;

  typedef enum logic [2:0] {
    MEMOP_NONE = 3'd0,
    MEMOP_LW   = 3'd1,
    MEMOP_SW   = 3'd2,
    MEMOP_LB   = 3'd3,
    MEMOP_LBU  = 3'd4,
    MEMOP_SB   = 3'd5
  } memop_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [BE_W-1:0] BE_LANE0 = 4'b0001;
  localparam logic [BE_W-1:0] BE_WORD  = 4'b1111;

  // Map the raw opcode onto memop_t; unused encodings fold to NONE.
  function automatic memop_t decode_memop(input logic [2:0] raw);
    memop_t op;
    case (raw)
      3'd1:    op = MEMOP_LW;
      3'd2:    op = MEMOP_SW;
      3'd3:    op = MEMOP_LB;
      3'd4:    op = MEMOP_LBU;
      3'd5:    op = MEMOP_SB;
      default: op = MEMOP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Purpose: combinational lane logic for the memory stage (the load_align block).
//   Store side: st_op_i, st_lane_i, wdata_i -> be_o (byte enables), wdata_o (lane data)
//   Load side : ld_op_i, ld_lane_i, rdata_i -> ld_data_o (selected, extended word;
//               zero for non-load ops so stores write back 0)
module mem_stage_load_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned n = DATA_W
) (
  input  memop_t          st_op_i,
  input  logic [1:0]      st_lane_i,
  input  logic [n-1:0]    wdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [n-1:0]    wdata_o,
  input  memop_t          ld_op_i,
  input  logic [1:0]      ld_lane_i,
  input  logic [n-1:0]    rdata_i,
  output logic [n-1:0]    ld_data_o
);

  logic [7:0] ld_byte;

  // Byte stores replicate the byte to every lane and enable only the target lane.
  always_comb begin : store_lanes
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    if (st_op_i == MEMOP_SB) begin
      be_o    = BE_LANE0 << st_lane_i;
      wdata_o = {(n/8){wdata_i[7:0]}};
    end
  end

  // Little-endian lane pick followed by sign or zero extension.
  always_comb begin : load_extract
    ld_byte   = rdata_i[{ld_lane_i, 3'b000} +: 8];
    ld_data_o = '0;
    case (ld_op_i)
      MEMOP_LW:  ld_data_o = rdata_i;
      MEMOP_LB:  ld_data_o = {{(n-8){ld_byte[7]}}, ld_byte};
      MEMOP_LBU: ld_data_o = {{(n-8){1'b0}}, ld_byte};
      default:   ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Purpose: memory-access stage behind the ALU. Passes ALU results through or runs a
//   single load/store over a req/ack memory port, then emits one writeback beat.
//   clk, nreset              : clock, synchronous active-low reset
//   ex_valid/ex_ready        : execute handshake (ready only while idle)
//   aluout, wdata, memop, rd, regwrite : execute-stage payload
//   mem_req/we/addr/wdata/be : memory request, held until mem_ack
//   mem_ack, mem_rdata       : memory completion and read data
//   wb_valid, wb_regwrite, wb_rd, wb_result, misalign : writeback beat
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned n = DATA_W
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [n-1:0]    aluout,
  input  logic [n-1:0]    wdata,
  input  logic [2:0]      memop,
  input  logic [RD_W-1:0] rd,
  input  logic            regwrite,
  output logic            mem_req,
  output logic            mem_we,
  output logic [n-1:0]    mem_addr,
  output logic [n-1:0]    mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [n-1:0]    mem_rdata,
  output logic            wb_valid,
  output logic            wb_regwrite,
  output logic [RD_W-1:0] wb_rd,
  output logic [n-1:0]    wb_result,
  output logic            misalign
);

  state_t          state_q;
  memop_t          op_q;
  logic [1:0]      lane_q;
  logic [RD_W-1:0] rd_q;
  logic            regwrite_q;

  memop_t          op_c;
  logic            accept_c;
  logic            is_store_c;
  logic            is_load_c;
  logic            misaligned_c;
  logic [BE_W-1:0] be_c;
  logic [n-1:0]    wdata_lane_c;
  logic [n-1:0]    ld_data_c;

  assign op_c         = decode_memop(memop);
  assign ex_ready     = (state_q == ST_IDLE);
  assign accept_c     = ex_valid && (state_q == ST_IDLE);
  assign is_store_c   = (op_c == MEMOP_SW) || (op_c == MEMOP_SB);
  assign is_load_c    = (op_c == MEMOP_LW) || (op_c == MEMOP_LB) || (op_c == MEMOP_LBU);
  assign misaligned_c = (op_c == MEMOP_LW) && (aluout[1:0] != 2'b00);

  // Store lanes come from the live request; load extraction uses the captured op/lane.
  mem_stage_load_align #(.n(n)) u_load_align (
    .st_op_i   (op_c),
    .st_lane_i (aluout[1:0]),
    .wdata_i   (wdata),
    .be_o      (be_c),
    .wdata_o   (wdata_lane_c),
    .ld_op_i   (op_q),
    .ld_lane_i (lane_q),
    .rdata_i   (mem_rdata),
    .ld_data_o (ld_data_c)
  );

  // Stage FSM, memory request registers and writeback registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      op_q        <= MEMOP_NONE;
      lane_q      <= 2'b00;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_result   <= '0;
      misalign    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (is_store_c || (is_load_c && !misaligned_c)) begin
              state_q    <= ST_ACCESS;
              mem_req    <= 1'b1;
              mem_we     <= is_store_c;
              mem_addr   <= {aluout[n-1:2], 2'b00};
              mem_be     <= be_c;
              mem_wdata  <= is_store_c ? wdata_lane_c : '0;
              op_q       <= op_c;
              lane_q     <= aluout[1:0];
              rd_q       <= rd;
              regwrite_q <= is_load_c && regwrite && (rd != '0);
            end else begin
              // Pass-through or faulting LW: one-cycle beat without touching memory.
              wb_valid    <= 1'b1;
              wb_rd       <= rd;
              misalign    <= misaligned_c;
              wb_regwrite <= !misaligned_c && regwrite && (rd != '0);
              wb_result   <= misaligned_c ? '0 : aluout;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            state_q     <= ST_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            wb_valid    <= 1'b1;
            wb_rd       <= rd_q;
            wb_regwrite <= regwrite_q;
            wb_result   <= ld_data_c;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Purpose: self-checking bench for mem_stage: directed vector table, hand-written
//   reset/ack corner sequences, and random transactions against a reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        nreset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] aluout;
  logic [31:0] wdata;
  logic [2:0]  memop;
  logic [4:0]  rd;
  logic        regwrite;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        misalign;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk         (clk),
    .nreset      (nreset),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .aluout      (aluout),
    .wdata       (wdata),
    .memop       (memop),
    .rd          (rd),
    .regwrite    (regwrite),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .wb_valid    (wb_valid),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .wb_result   (wb_result),
    .misalign    (misalign)
  );

  typedef struct {
    logic        access;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        wb_rw;
    logic [31:0] wb_res;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        rw;
    int          dly;
    logic [31:0] rdv;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic        timeout;
    logic        ready_issue;
    logic        saw_req;
    int          lat;
    logic        stable;
    logic        stall_ok;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic        mis;
    logic        ready_wb;
    logic        req_wb;
    logic        pulse_after;
    logic        hold_ok;
  } obs_t;

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [2:0] op, logic [31:0] addr, logic [31:0] wd,
                              logic [4:0] r, logic rw, int dly, logic [31:0] rdv,
                              logic acc, logic we, logic [3:0] be, logic [31:0] ma,
                              logic [31:0] mw, logic wrw, logic [31:0] wres, logic mis);
    vec_t v;
    v.op = op; v.addr = addr; v.wd = wd; v.rd = r; v.rw = rw; v.dly = dly; v.rdv = rdv;
    v.e.access = acc; v.e.we = we; v.e.be = be; v.e.maddr = ma; v.e.mwdata = mw;
    v.e.wb_rw = wrw; v.e.wb_res = wres; v.e.mis = mis;
    return v;
  endfunction

  // Reference model: what the stage should do, derived from byte arithmetic.
  function automatic exp_t model(vec_t v);
    exp_t        e;
    int          lane;
    logic [31:0] b;
    e = '{default: '0};
    lane    = int'(v.addr % 32'd4);
    e.maddr = v.addr - 32'(lane);
    b       = (v.rdv >> (8 * lane)) & 32'hFF;
    case (v.op)
      3'd1: begin
        if (lane != 0) e.mis = 1'b1;
        else begin
          e.access = 1'b1; e.be = 4'hF; e.wb_res = v.rdv;
          e.wb_rw = v.rw && (v.rd != 5'd0);
        end
      end
      3'd2: begin
        e.access = 1'b1; e.we = 1'b1; e.be = 4'hF; e.mwdata = v.wd;
      end
      3'd3, 3'd4: begin
        if (v.op == 3'd3 && b >= 32'd128) b = b - 32'd256;
        e.access = 1'b1; e.be = 4'hF; e.wb_res = b;
        e.wb_rw = v.rw && (v.rd != 5'd0);
      end
      3'd5: begin
        e.access = 1'b1; e.we = 1'b1; e.be = 4'(1 << lane);
        e.mwdata = (v.wd & 32'hFF) * 32'h0101_0101;
      end
      default: begin
        e.wb_res = v.addr;
        e.wb_rw  = v.rw && (v.rd != 5'd0);
      end
    endcase
    return e;
  endfunction

  // Issue one transaction at a negedge, act as memory, observe the writeback beat.
  task automatic run_txn(input vec_t v, output obs_t o);
    int cyc;
    int reqcnt;
    o = '{default: '0};
    o.stable   = 1'b1;
    o.stall_ok = 1'b1;
    ex_valid = 1'b1; memop = v.op; aluout = v.addr; wdata = v.wd;
    rd = v.rd; regwrite = v.rw;
    o.ready_issue = ex_ready;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    cyc = 1;
    reqcnt = 0;
    while (cyc <= 40 && !wb_valid) begin
      mem_rdata = $urandom;
      if (mem_req) begin
        if (reqcnt == 0) begin
          o.saw_req = 1'b1;
          o.we = mem_we; o.be = mem_be; o.maddr = mem_addr; o.mwdata = mem_wdata;
        end else if (mem_we !== o.we || mem_be !== o.be || mem_addr !== o.maddr ||
                     mem_wdata !== o.mwdata) begin
          o.stable = 1'b0;
        end
        if (ex_ready) o.stall_ok = 1'b0;
        reqcnt++;
        if (reqcnt > v.dly) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdv;
        end
      end
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      cyc++;
    end
    o.timeout  = !wb_valid;
    o.lat      = cyc;
    o.wb_rw    = wb_regwrite;
    o.wb_rd    = wb_rd;
    o.wb_res   = wb_result;
    o.mis      = misalign;
    o.ready_wb = ex_ready;
    o.req_wb   = mem_req;
    @(posedge clk);
    @(negedge clk);
    o.pulse_after = wb_valid || misalign;
    o.hold_ok     = (wb_result === o.wb_res) && (wb_rd === o.wb_rd);
  endtask

  task automatic check_txn(input string tag, input vec_t v, input obs_t o);
    check(tag, "timeout", 32'(o.timeout), 32'd0);
    check(tag, "ready_issue", 32'(o.ready_issue), 32'd1);
    check(tag, "mem_req_seen", 32'(o.saw_req), 32'(v.e.access));
    check(tag, "latency", 32'(o.lat), v.e.access ? 32'(v.dly + 2) : 32'd1);
    check(tag, "wb_regwrite", 32'(o.wb_rw), 32'(v.e.wb_rw));
    check(tag, "wb_rd", 32'(o.wb_rd), 32'(v.rd));
    check(tag, "misalign", 32'(o.mis), 32'(v.e.mis));
    if (!v.e.mis) check(tag, "wb_result", o.wb_res, v.e.wb_res);
    if (v.e.access) begin
      check(tag, "mem_we", 32'(o.we), 32'(v.e.we));
      check(tag, "mem_be", 32'(o.be), 32'(v.e.be));
      check(tag, "mem_addr", o.maddr, v.e.maddr);
      check(tag, "req_stable", 32'(o.stable), 32'd1);
      check(tag, "stall", 32'(o.stall_ok), 32'd1);
      if (v.e.we) check(tag, "mem_wdata", o.mwdata, v.e.mwdata);
    end
    check(tag, "ready_at_wb", 32'(o.ready_wb), 32'd1);
    check(tag, "req_at_wb", 32'(o.req_wb), 32'd0);
    check(tag, "wb_pulse", 32'(o.pulse_after), 32'd0);
    check(tag, "wb_hold", 32'(o.hold_ok), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    vec_t v;
    obs_t o;

    tbl[0]  = mk(3'd0, 32'h0000_1234, 32'h0, 5'd8, 1'b1, 0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_1234, 1'b0);
    tbl[1]  = mk(3'd2, 32'h40, 32'hDEAD_BEEF, 5'd3, 1'b0, 2, 32'h0,
                 1'b1, 1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    tbl[2]  = mk(3'd3, 32'h43, 32'h0, 5'd5, 1'b1, 1, 32'h80FF_0000,
                 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
    tbl[3]  = mk(3'd4, 32'h43, 32'h0, 5'd5, 1'b1, 1, 32'h80FF_0000,
                 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b1, 32'h0000_0080, 1'b0);
    tbl[4]  = mk(3'd5, 32'h22, 32'h0000_00A5, 5'd6, 1'b1, 0, 32'h0,
                 1'b1, 1'b1, 4'b0100, 32'h20, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0);
    tbl[5]  = mk(3'd1, 32'h41, 32'h0, 5'd7, 1'b1, 0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tbl[6]  = mk(3'd1, 32'h100, 32'h0, 5'd0, 1'b1, 0, 32'h1234_5678,
                 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 32'h1234_5678, 1'b0);
    tbl[7]  = mk(3'd1, 32'h104, 32'h0, 5'd31, 1'b1, 1, 32'hCAFE_F00D,
                 1'b1, 1'b0, 4'hF, 32'h104, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
    tbl[8]  = mk(3'd7, 32'h0000_ABCD, 32'h0, 5'd2, 1'b1, 0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_ABCD, 1'b0);
    tbl[9]  = mk(3'd3, 32'h10, 32'h0, 5'd9, 1'b1, 0, 32'hAABB_CC7F,
                 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 32'h0000_007F, 1'b0);
    tbl[10] = mk(3'd5, 32'h13, 32'h1234_5699, 5'd10, 1'b0, 3, 32'h0,
                 1'b1, 1'b1, 4'b1000, 32'h10, 32'h9999_9999, 1'b0, 32'h0, 1'b0);
    tbl[11] = mk(3'd2, 32'h47, 32'h0BAD_F00D, 5'd11, 1'b0, 1, 32'h0,
                 1'b1, 1'b1, 4'hF, 32'h44, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0);
    tbl[12] = mk(3'd0, 32'hFFFF_0000, 32'h0, 5'd0, 1'b1, 0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'hFFFF_0000, 1'b0);
    tbl[13] = mk(3'd4, 32'h21, 32'h0, 5'd12, 1'b1, 0, 32'h0000_C300,
                 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, 32'h0000_00C3, 1'b0);
    tbl[14] = mk(3'd3, 32'h21, 32'h0, 5'd12, 1'b0, 2, 32'h0000_C300,
                 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 32'hFFFF_FFC3, 1'b0);

    nreset = 1'b0; ex_valid = 1'b0; aluout = '0; wdata = '0; memop = '0;
    rd = '0; regwrite = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", "mem_req", 32'(mem_req), 32'd0);
    check("reset", "mem_we", 32'(mem_we), 32'd0);
    check("reset", "mem_be", 32'(mem_be), 32'd0);
    check("reset", "mem_addr", mem_addr, 32'd0);
    check("reset", "mem_wdata", mem_wdata, 32'd0);
    check("reset", "wb_valid", 32'(wb_valid), 32'd0);
    check("reset", "wb_regwrite", 32'(wb_regwrite), 32'd0);
    check("reset", "wb_rd", 32'(wb_rd), 32'd0);
    check("reset", "wb_result", wb_result, 32'd0);
    check("reset", "misalign", 32'(misalign), 32'd0);
    check("reset", "ex_ready", 32'(ex_ready), 32'd1);
    nreset = 1'b1;

    foreach (tbl[i]) begin
      run_txn(tbl[i], o);
      check_txn($sformatf("vec%0d", i), tbl[i], o);
    end

    // Ack with no request outstanding must be ignored.
    mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_ack", "wb_valid", 32'(wb_valid), 32'd0);
    check("stray_ack", "mem_req", 32'(mem_req), 32'd0);
    check("stray_ack", "ex_ready", 32'(ex_ready), 32'd1);

    // Reset in the middle of a store: access abandoned, no writeback.
    ex_valid = 1'b1; memop = 3'd2; aluout = 32'h80; wdata = 32'h55; rd = 5'd4;
    regwrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    check("rst_mid", "req_before", 32'(mem_req), 32'd1);
    check("rst_mid", "ready_before", 32'(ex_ready), 32'd0);
    nreset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid", "mem_req", 32'(mem_req), 32'd0);
    check("rst_mid", "mem_we", 32'(mem_we), 32'd0);
    check("rst_mid", "mem_be", 32'(mem_be), 32'd0);
    check("rst_mid", "mem_addr", mem_addr, 32'd0);
    check("rst_mid", "mem_wdata", mem_wdata, 32'd0);
    check("rst_mid", "wb_result", wb_result, 32'd0);
    check("rst_mid", "wb_valid", 32'(wb_valid), 32'd0);
    mem_ack = 1'b1;
    nreset  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("rst_mid", "wb_after_ack", 32'(wb_valid), 32'd0);
    check("rst_mid", "req_after_ack", 32'(mem_req), 32'd0);
    check("rst_mid", "ex_ready", 32'(ex_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid", "wb_late", 32'(wb_valid), 32'd0);

    v = mk(3'd1, 32'h200, 32'h0, 5'd0, 1'b1, 0, 32'hFFFF_FFFF,
           1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    run_txn(v, o);
    check_txn("lw_rd0_after_rst", v, o);

    for (int i = 0; i < 40; i++) begin
      v.op   = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      v.wd   = $urandom;
      v.rd   = 5'($urandom);
      v.rw   = 1'($urandom);
      v.dly  = int'($urandom_range(0, 3));
      v.rdv  = $urandom;
      v.e    = model(v);
      run_txn(v, o);
      check_txn($sformatf("rand%0d", i), v, o);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
